// File: rtl/enigma_pkg.sv
// Shared constants and FSM state encoding for the scrambler front-end blocks.
package enigma_pkg;
  localparam int NUM_LETTERS = 26;
  localparam int LETTER_W = 5;
  localparam logic [LETTER_W-1:0] LETTER_ERR = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    ERROR = 2'd3
  } state_t;
endpackage

// File: rtl/key_sequencer_if.sv
// Bundle of upstream letter, core key/lamp and downstream result signals around key_sequencer.
interface key_sequencer_if;
  import enigma_pkg::*;

  // Both letter channels use valid/ready: a transfer happens on a rising edge where
  // valid & ready are both high; the producer holds its data stable while valid & ~ready.
  logic [LETTER_W-1:0]    in_letter;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_LETTERS-1:0] key;
  logic [NUM_LETTERS-1:0] lamp;
  logic [LETTER_W-1:0]    out_letter;
  logic                   out_err;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  modport master (
    output in_letter, in_valid, lamp, out_ready,
    input  in_ready, key, out_letter, out_err, out_valid, busy
  );

  modport slave (
    input  in_letter, in_valid, lamp, out_ready,
    output in_ready, key, out_letter, out_err, out_valid, busy
  );
endinterface

// File: rtl/onehot_encode26.sv
// Combinational 26-bit one-hot to letter index encoder with an exactly-one-bit check.
module onehot_encode26
  import enigma_pkg::*;
(
  input  logic [NUM_LETTERS-1:0] i_vec,
  output logic [LETTER_W-1:0]    o_index,
  output logic                   o_one_hot_ok
);
  always_comb begin
    o_index = '0;
    for (int i = NUM_LETTERS - 1; i >= 0; i--) begin
      if (i_vec[i]) o_index = LETTER_W'(i);
    end
    // x & (x-1) clears the lowest set bit, so zero means at most one bit was set
    o_one_hot_ok = (i_vec != '0) && ((i_vec & (i_vec - NUM_LETTERS'(1))) == '0);
  end
endmodule

// File: rtl/key_sequencer.sv
// Presses one key per accepted letter for a fixed window, samples the lamp, and returns the encoded letter.
module key_sequencer
  import enigma_pkg::*;
#(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic            clk,
  input  logic            reset,
  key_sequencer_if.slave  bus,
  output state_t          o_state
);
  localparam int CNT_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_LETTERS-1:0] r_key;
  logic                   r_out_valid;
  logic [LETTER_W-1:0]    r_out_letter;
  logic                   r_out_err;

  logic                   w_in_ready;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_letter_ok;
  logic [LETTER_W-1:0]    w_lamp_idx;
  logic                   w_lamp_ok;

  onehot_encode26 u_lamp_enc (
    .i_vec        (bus.lamp),
    .o_index      (w_lamp_idx),
    .o_one_hot_ok (w_lamp_ok)
  );

  // A parked result blocks new letters so it can never be overwritten.
  assign w_in_ready  = ~reset & (r_state == IDLE) & ~r_out_valid;
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = r_out_valid & bus.out_ready;
  assign w_letter_ok = bus.in_letter < LETTER_W'(NUM_LETTERS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_key        <= '0;
      r_out_valid  <= 1'b0;
      r_out_letter <= '0;
      r_out_err    <= 1'b0;
    end else begin
      if (w_out_fire) r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            if (w_letter_ok) begin
              r_state <= PRESS;
              r_cnt   <= PRESS_LOAD;
              r_key   <= NUM_LETTERS'(1) << bus.in_letter;
            end else begin
              // Illegal letter: report it without ever touching the key vector.
              r_state      <= ERROR;
              r_cnt        <= '0;
              r_out_valid  <= 1'b1;
              r_out_letter <= LETTER_ERR;
              r_out_err    <= 1'b1;
            end
          end
        end
        PRESS: begin
          if (r_cnt == '0) begin
            r_state      <= GAP;
            r_cnt        <= GAP_LOAD;
            r_key        <= '0;
            r_out_valid  <= 1'b1;
            r_out_letter <= w_lamp_ok ? w_lamp_idx : LETTER_ERR;
            r_out_err    <= ~w_lamp_ok;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ERROR: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_key   <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.key        = r_key;
  assign bus.out_letter = r_out_letter;
  assign bus.out_err    = r_out_err;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = (r_state != IDLE);
  assign o_state        = r_state;
endmodule
